// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and default widths for acc_n
package acc_pkg;

  // Frame controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default sample/sum width and frame-length field width
  localparam int N_DEF     = 32;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/adder_n.sv
// rtl/adder_n.sv - n-bit ripple-carry adder, sum only (carry-out deliberately not exported)
module adder_n #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] sum
);

  // c[i] is the carry into bit i; the carry out of the top bit is not needed
  logic [n-1:0] c;

  assign c[0] = 1'b0;

  // One full adder per bit, carries rippling upward
  genvar i;
  for (i = 0; i < n; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    if (i < n - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/acc_n.sv
// rtl/acc_n.sv - framed unsigned accumulator with sticky overflow; ACC_N_SAT_EN selects saturating sums
module acc_n
  import acc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [N-1:0]     sum_raw;
  logic             carry;
  logic [N-1:0]     acc_nxt;
  logic             xfer;

  adder_n #(.n(N)) u_add (
    .a   (acc),
    .b   (in_data),
    .sum (sum_raw)
  );

  // Carry-out is inferred from the wrapped sum falling below the old accumulator
  always_comb begin
    carry = (sum_raw < acc);
`ifdef ACC_N_SAT_EN
    acc_nxt = carry ? {N{1'b1}} : sum_raw;
`else
    acc_nxt = sum_raw;
`endif
  end

  assign xfer = in_valid && (state == ACC);

  // Frame controller: clear beats everything except reset; start only honoured in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= len;
            state <= (len == '0) ? DONE : ACC;
          end
        end
        ACC: begin
          if (xfer) begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_ONE;
            if (carry) begin
              ovf <= 1'b1;
            end
            if (cnt == CNT_ONE) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and status outputs are pure decodes of the registered state
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
    busy      = (state == ACC) || (state == DONE);
    out_sum   = acc;
    out_ovf   = ovf;
  end

endmodule
